// File: rtl/ram_loader.sv
// ram_loader: receives a 17-byte frame (16 program bytes and a checksum),
// writes the program bytes to RAM addresses 0..15 and holds the CPU in halt
// while loading. A good checksum ends in DONE with a one-cycle CPU restart
// pulse. A bad checksum or a stalled stream ends in ERR.
module ram_loader #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_mode,
  output logic [3:0] prog_addr,
  output logic [7:0] program_data,
  output logic       cpu_halt,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  localparam int unsigned DATA_BYTES = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned TMO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    byte_count_q;
  logic [BYTE_W-1:0]   sum_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                in_ready_q;
  logic                prog_mode_q;
  logic [ADDR_W-1:0]   prog_addr_q;
  logic [BYTE_W-1:0]   program_data_q;
  logic                cpu_halt_q;
  logic                cpu_reset_q;
  logic                done_q;
  logic                error_q;

  logic                accept_c;
  logic                is_cksum_c;
  logic                cksum_ok_c;
  logic                tmo_hit_c;
  logic [BYTE_W-1:0]   sum_d;
  logic [CNT_W-1:0]    byte_count_d;

  // Handshake, frame position and checksum decode for the current cycle.
  assign accept_c     = (state_q == S_LOAD) && in_valid && in_ready_q;
  assign is_cksum_c   = (byte_count_q == CNT_W'(DATA_BYTES));
  assign cksum_ok_c   = (in_data == sum_q);
  assign tmo_hit_c    = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT));
  assign sum_d        = sum_q + in_data;
  assign byte_count_d = byte_count_q + CNT_W'(1);

  // Loader FSM with registered outputs; an accepted byte takes priority over a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      byte_count_q   <= '0;
      sum_q          <= '0;
      tmo_q          <= '0;
      in_ready_q     <= 1'b0;
      prog_mode_q    <= 1'b0;
      prog_addr_q    <= '0;
      program_data_q <= '0;
      cpu_halt_q     <= 1'b0;
      cpu_reset_q    <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      prog_mode_q <= 1'b0;
      cpu_reset_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LOAD;
            byte_count_q <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            cpu_halt_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept_c) begin
            tmo_q <= '0;
            if (is_cksum_c) begin
              state_q     <= cksum_ok_c ? S_DONE : S_ERR;
              done_q      <= cksum_ok_c;
              error_q     <= !cksum_ok_c;
              cpu_reset_q <= cksum_ok_c;
              in_ready_q  <= 1'b0;
              cpu_halt_q  <= 1'b0;
            end else begin
              prog_mode_q    <= 1'b1;
              prog_addr_q    <= byte_count_q[ADDR_W-1:0];
              program_data_q <= in_data;
              sum_q          <= sum_d;
              byte_count_q   <= byte_count_d;
            end
          end else if (tmo_hit_c) begin
            state_q    <= S_ERR;
            error_q    <= 1'b1;
            in_ready_q <= 1'b0;
            cpu_halt_q <= 1'b0;
          end else if (TIMEOUT != 0) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign prog_mode    = prog_mode_q;
  assign prog_addr    = prog_addr_q;
  assign program_data = program_data_q;
  assign cpu_halt     = cpu_halt_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: directed frames plus randomized frames with gaps.
// The driver derives expected RAM writes and final status from the frame
// contents and gap pattern; a monitor pops expected writes on each prog_mode.
module tb_ram_loader;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       prog_mode;
  logic [3:0] prog_addr;
  logic [7:0] program_data;
  logic       cpu_halt;
  logic       cpu_reset;
  logic       done;
  logic       error;

  ram_loader #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .prog_mode    (prog_mode),
    .prog_addr    (prog_addr),
    .program_data (program_data),
    .cpu_halt     (cpu_halt),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          creset_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [7:0]  fr_data[17];
  int          fr_gap[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write must match the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("done_error_exclusive", 32'(done && error), 32'd0);
      if (cpu_reset === 1'b1) creset_cnt++;
      if (prog_mode === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=0x%0h while no write was expected (t=%0t)",
                   prog_addr, program_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("prog_addr", 32'(prog_addr), 32'(mon_e[11:8]));
          chk("program_data", 32'(program_data), 32'(mon_e[7:0]));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_prog_mode"}, 32'(prog_mode), 32'd0);
    chk({tag, "_prog_addr"}, 32'(prog_addr), 32'd0);
    chk({tag, "_program_data"}, 32'(program_data), 32'd0);
    chk({tag, "_cpu_halt"}, 32'(cpu_halt), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Send fr_data with fr_gap idle cycles before each byte; expectations come
  // from the frame rules: a gap longer than TMO ends the load in ERR.
  task automatic run_frame(input bit mid_start);
    int         stop_at;
    bit         to;
    int         s;
    bit         exp_done;
    int         cr0;
    to      = 1'b0;
    stop_at = 17;
    for (int i = 0; i < 17; i++) begin
      if (!to && fr_gap[i] > TMO) begin
        to      = 1'b1;
        stop_at = i;
      end
    end
    s = 0;
    for (int i = 0; i < 16; i++) s = s + int'(fr_data[i]);
    exp_done = !to && (8'(s % 256) == fr_data[16]);
    for (int i = 0; i < 16 && i < stop_at; i++) exp_q.push_back({4'(i), fr_data[i]});
    cr0 = creset_cnt;

    @(posedge clk); #1;
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_cpu_halt", 32'(cpu_halt), 32'd1);
    chk("load_done_cleared", 32'(done), 32'd0);
    chk("load_error_cleared", 32'(error), 32'd0);

    for (int i = 0; i < stop_at; i++) begin
      in_valid = 1'b0;
      repeat (fr_gap[i]) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = fr_data[i];
      start    = mid_start && (i == 5);
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;

    if (to) begin
      repeat (TMO) begin @(posedge clk); #1; end
      chk("timeout_not_early", 32'(error), 32'd0);
      @(posedge clk); #1;
      chk("timeout_error", 32'(error), 32'd1);
      chk("timeout_done", 32'(done), 32'd0);
      chk("timeout_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("timeout_in_ready", 32'(in_ready), 32'd0);
    end else begin
      chk("end_done", 32'(done), 32'(exp_done));
      chk("end_error", 32'(error), 32'(!exp_done));
      chk("end_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("end_in_ready", 32'(in_ready), 32'd0);
      chk("end_cpu_reset", 32'(cpu_reset), 32'(exp_done));
      @(posedge clk); #1;
      chk("cpu_reset_one_cycle", 32'(cpu_reset), 32'd0);
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("cpu_reset_pulse_count", 32'(creset_cnt - cr0), 32'(exp_done));
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_counting(input logic [7:0] ck, input int gap);
    for (int i = 0; i < 16; i++) begin
      fr_data[i] = 8'(i + 1);
      fr_gap[i]  = gap;
    end
    fr_data[16] = ck;
    fr_gap[16]  = gap;
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int s;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Idle: bytes offered without start are not accepted.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_cpu_halt", 32'(cpu_halt), 32'd0);
    in_valid = 1'b0;

    // Good frame, back-to-back.
    set_counting(8'h88, 0);
    run_frame(1'b0);
    // Bad checksum (also confirms start after DONE clears done).
    set_counting(8'h89, 0);
    run_frame(1'b0);
    // Good frame after ERR, with start pulsed mid-load.
    set_counting(8'h88, 0);
    run_frame(1'b1);
    // Five-cycle gaps complete normally.
    set_counting(8'h88, 5);
    run_frame(1'b0);
    // Nine-cycle gap after byte 3 times out; addresses 0..3 only.
    set_counting(8'h88, 0);
    fr_gap[4] = 9;
    run_frame(1'b0);
    // Byte arriving exactly when the counter reaches TMO is accepted.
    set_counting(8'h88, 0);
    fr_gap[0]  = TMO;
    fr_gap[4]  = TMO;
    fr_gap[16] = TMO;
    run_frame(1'b0);

    // Reset after byte 7: everything clears, no further writes.
    set_counting(8'h88, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), fr_data[i]});
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = fr_data[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_reset_cpu_halt", 32'(cpu_halt), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midload_reset");
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_reset_in_ready", 32'(in_ready), 32'd0);
    chk("post_reset_cpu_halt", 32'(cpu_halt), 32'd0);
    chk("post_reset_prog_addr", 32'(prog_addr), 32'd0);
    chk("post_reset_writes_outstanding", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    // Randomized frames.
    for (int r = 0; r < 24; r++) begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        fr_data[i] = 8'($urandom);
        s = s + int'(fr_data[i]);
      end
      for (int i = 0; i < 17; i++) begin
        fr_gap[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 0;
      end
      fr_data[16] = ($urandom_range(0, 1) == 1) ? 8'(s % 256) : 8'($urandom);
      run_frame($urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter TIMEOUT, default 4095: maximum idle cycles between accepted bytes while loading; 0 disables the timeout.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 prog_mode  output  1  RAM program-write strobe, one cycle per data byte.
REQ-009 prog_addr  output  4  RAM program address.
REQ-010 program_data  output  8  RAM program data.
REQ-011 cpu_halt  output  1  holds the CPU stopped while loading.
REQ-012 cpu_reset  output  1  one-cycle CPU restart pulse after a good load.
REQ-013 done  output  1  last load completed with a correct checksum.
REQ-014 error  output  1  last load failed (checksum mismatch or timeout).

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, DONE and ERR.
REQ-016 Frame format SHALL be 17 bytes: data bytes 0..15 go to RAM addresses 0..15 in order; byte 16 is the checksum (8-bit sum of the 16 data bytes, modulo 256) and is not written.
REQ-017 A byte SHALL be accepted on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in LOAD.
REQ-018 start in IDLE, DONE or ERR SHALL move the FSM to LOAD next cycle, clearing byte_count (5-bit), sum, timeout counter, done and error; start in LOAD SHALL be ignored.
REQ-019 On acceptance of data byte k (k=0..15), the next cycle SHALL have prog_mode=1, prog_addr=k, program_data=byte; prog_mode SHALL be 0 in all other cycles.
REQ-020 Back-to-back acceptance (in_valid held high) SHALL be supported at one byte per cycle, giving consecutive prog_mode pulses with incrementing prog_addr.
REQ-021 prog_addr and program_data SHALL hold their last values when prog_mode=0.
REQ-022 Sum SHALL accumulate each accepted data byte modulo 256; carries are discarded.
REQ-023 On acceptance of byte 16: if in_data equals sum, next state DONE and done=1; otherwise next state ERR and error=1.
REQ-024 cpu_reset SHALL be 1 for exactly the first cycle in DONE; it is never asserted on entry to ERR.
REQ-025 cpu_halt SHALL be 1 in LOAD and 0 in IDLE, DONE and ERR.
REQ-026 done and error SHALL stay asserted until the next accepted start or reset, and SHALL never both be 1.
REQ-027 With TIMEOUT>0, the timeout counter SHALL clear on LOAD entry and on every accepted byte and increment every other LOAD cycle; when it reaches TIMEOUT, the FSM SHALL go to ERR next cycle with error=1.
REQ-028 If a byte is accepted in the cycle the counter reaches TIMEOUT, the byte SHALL win and the timeout SHALL not fire.
REQ-029 When the FSM leaves LOAD early (timeout), RAM locations already written SHALL keep their data; no further prog_mode pulses SHALL occur.
REQ-030 byte_count SHALL never exceed 16; no byte is accepted outside LOAD.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and set all outputs to 0: in_ready, prog_mode, prog_addr=0, program_data=0, cpu_halt, cpu_reset, done, error; byte_count, sum and timeout counter SHALL also be 0.
REQ-032 A reset during LOAD SHALL abort the frame with no further RAM writes; after rst is released, a start SHALL be needed to load.

Verification
REQ-033 Good frame: start, then bytes 0x01..0x10 and checksum 0x88, back-to-back -> 16 prog_mode pulses at addr 0..15 with data 0x01..0x10, cpu_reset pulses once, done=1, error=0, cpu_halt drops.
REQ-034 Bad checksum: same data, checksum 0x89 -> 16 writes, error=1, done=0, no cpu_reset pulse.
REQ-035 Gapped stream, TIMEOUT=8: 5-cycle gaps between bytes -> load completes with done=1; a 9-cycle gap after byte 3 -> error=1 in the cycle after the counter reaches 8, and only addresses 0..3 are written.
REQ-036 Byte arrives in the cycle the counter reaches TIMEOUT -> byte accepted and written, no error.
REQ-037 rst asserted after byte 7 -> all outputs 0 immediately, no further prog_mode pulses; start is ignored mid-LOAD, and start after DONE clears done and begins a new frame.
